// File: rtl/histogram_reader.sv
// Histogram read-out engine. Sweeps every bin of the data_statistics RAM,
// streams (bin, count) entries over a valid/ready port and keeps running
// total / peak-bin statistics for the most recent sweep.
//
// Handshake: an output entry transfers on any rising clock edge where
// out_vld && out_rdy. While out_vld is high and out_rdy is low, out_vld,
// out_bin, out_cnt and out_last hold their values. out_vld never depends
// on out_rdy.
module histogram_reader #(
  parameter int DSIZE      = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SKIP_ZERO  = 0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  dump_req,
  input  logic                  abort,
  output logic                  get_summary,
  output logic [DSIZE-1:0]      index,
  input  logic [31:0]           summary,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DSIZE-1:0]      out_bin,
  output logic [31:0]           out_cnt,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [32+DSIZE-1:0]   total,
  output logic [DSIZE-1:0]      max_bin,
  output logic [31:0]           max_cnt,
  output logic [1:0]            state_dbg
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [DSIZE-1:0] LAST_BIN = '1;
  localparam bit SKIP = (SKIP_ZERO != 0);

  // The credit scheme needs room for every read that can be in flight.
  if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
    $error("histogram_reader: FIFO_DEPTH must be >= RD_LAT+1");
  end
  if (RD_LAT < 1) begin : g_lat_check
    $error("histogram_reader: RD_LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [RD_LAT-1:0] tag_vld;
  logic [DSIZE-1:0]  tag_bin [RD_LAT];
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     free_slots;
  logic              start;
  logic              issue;
  logic              cap;
  logic              push;
  logic              pop;
  logic [DSIZE-1:0]  cap_bin;
  logic              cap_last;

  logic [DSIZE-1:0]  mem_bin  [FIFO_DEPTH];
  logic [31:0]       mem_cnt  [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Reads in flight = valid tags in the latency pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(tag_vld[i]);
    end
  end

  assign free_slots = CW'(FIFO_DEPTH) - fifo_cnt;
  assign start      = (state == S_IDLE) && dump_req && !abort;
  assign issue      = (state == S_ISSUE) && (free_slots > inflight) && !abort;
  assign cap        = tag_vld[RD_LAT-1] && !abort;
  assign cap_bin    = tag_bin[RD_LAT-1];
  assign cap_last   = !SKIP && (cap_bin == LAST_BIN);
  assign push       = cap && !(SKIP && (summary == 32'd0));
  assign pop        = out_vld && out_rdy;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, including dump_req.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dump_req) state_nxt = S_ISSUE;
      S_ISSUE: if (issue && (index == LAST_BIN)) state_nxt = S_DRAIN;
      S_DRAIN: if ((inflight == '0) && (fifo_cnt == '0)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign get_summary = (state == S_ISSUE) || (state == S_DRAIN);
  assign state_dbg   = state;

  // Read address: restarts at bin 0 on a new sweep, advances per issued read, never wraps.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                                index <= '0;
    else if (start)                            index <= '0;
    else if (issue && (index != LAST_BIN))     index <= index + DSIZE'(1);
  end

  // Tag pipeline: tracks which bin the RAM returns RD_LAT cycles after issue.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_bin[i] <= '0;
    end else if (abort) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_bin[0] <= index;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_bin[i] <= tag_bin[i-1];
      end
    end
  end

  // Sweep statistics: cleared at sweep start, held after done until the next sweep.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      total   <= '0;
      max_cnt <= '0;
      max_bin <= '0;
    end else if (start) begin
      total   <= '0;
      max_cnt <= '0;
      max_bin <= '0;
    end else if (cap) begin
      total <= total + (32+DSIZE)'(summary);
      if (summary > max_cnt) begin
        max_cnt <= summary;
        max_bin <= cap_bin;
      end
    end
  end

  // FIFO pointers and occupancy; abort discards everything buffered.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_bin[wr_ptr]  <= cap_bin;
      mem_cnt[wr_ptr]  <= summary;
      mem_last[wr_ptr] <= cap_last;
    end
  end

  // First-word-fall-through head; zero while empty.
  always_comb begin
    out_vld  = (fifo_cnt != '0);
    out_bin  = '0;
    out_cnt  = '0;
    out_last = 1'b0;
    if (out_vld) begin
      out_bin  = mem_bin[rd_ptr];
      out_cnt  = mem_cnt[rd_ptr];
      out_last = mem_last[rd_ptr];
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(push && (fifo_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_histogram_reader.sv
// Bench for histogram_reader: one instance streaming every bin, one with
// zero-count bins suppressed. Each instance has a small latency RAM model.
module tb_histogram_reader;

  localparam int DSIZE  = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int NB     = 1 << DSIZE;
  localparam int EW     = 1 + DSIZE + 32;
  localparam int TW     = 32 + DSIZE;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instance A (all bins) ----------------
  logic             dump_req_a = 1'b0, abort_a = 1'b0, out_rdy_a = 1'b1;
  logic             get_summary_a, out_vld_a, out_last_a, busy_a, done_a;
  logic [DSIZE-1:0] index_a, out_bin_a, max_bin_a;
  logic [31:0]      summary_a, out_cnt_a, max_cnt_a;
  logic [TW-1:0]    total_a;
  logic [1:0]       state_a;
  logic [31:0]      mem_a [NB];
  logic [DSIZE-1:0] rd_pipe_a [RD_LAT];

  histogram_reader #(.DSIZE(DSIZE), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .SKIP_ZERO(0)) dut (
    .clock(clock), .rst_n(rst_n), .dump_req(dump_req_a), .abort(abort_a),
    .get_summary(get_summary_a), .index(index_a), .summary(summary_a),
    .out_vld(out_vld_a), .out_rdy(out_rdy_a), .out_bin(out_bin_a), .out_cnt(out_cnt_a),
    .out_last(out_last_a), .busy(busy_a), .done(done_a), .total(total_a),
    .max_bin(max_bin_a), .max_cnt(max_cnt_a), .state_dbg(state_a)
  );

  // ---------------- instance B (zero bins skipped) ----------------
  logic             dump_req_b = 1'b0, abort_b = 1'b0, out_rdy_b = 1'b1;
  logic             get_summary_b, out_vld_b, out_last_b, busy_b, done_b;
  logic [DSIZE-1:0] index_b, out_bin_b, max_bin_b;
  logic [31:0]      summary_b, out_cnt_b, max_cnt_b;
  logic [TW-1:0]    total_b;
  logic [1:0]       state_b;
  logic [31:0]      mem_b [NB];
  logic [DSIZE-1:0] rd_pipe_b [RD_LAT];

  histogram_reader #(.DSIZE(DSIZE), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH), .SKIP_ZERO(1)) dut_sz (
    .clock(clock), .rst_n(rst_n), .dump_req(dump_req_b), .abort(abort_b),
    .get_summary(get_summary_b), .index(index_b), .summary(summary_b),
    .out_vld(out_vld_b), .out_rdy(out_rdy_b), .out_bin(out_bin_b), .out_cnt(out_cnt_b),
    .out_last(out_last_b), .busy(busy_b), .done(done_b), .total(total_b),
    .max_bin(max_bin_b), .max_cnt(max_cnt_b), .state_dbg(state_b)
  );

  // RAM models: summary reflects the index presented RD_LAT cycles earlier.
  always @(posedge clock) begin
    rd_pipe_a[0] <= index_a;
    rd_pipe_b[0] <= index_b;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe_a[i] <= rd_pipe_a[i-1];
      rd_pipe_b[i] <= rd_pipe_b[i-1];
    end
  end
  assign summary_a = mem_a[rd_pipe_a[RD_LAT-1]];
  assign summary_b = mem_b[rd_pipe_b[RD_LAT-1]];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  logic [TW-1:0] exp_total;
  logic [31:0]   exp_max_cnt;
  logic [DSIZE-1:0] exp_max_bin;

  // Reference model of one sweep over the selected RAM image.
  task automatic load_expect(input bit sel);
    logic [TW-1:0] t;
    logic [31:0]   mc, c;
    logic [DSIZE-1:0] mb;
    logic lst;
    t = '0; mc = '0; mb = '0;
    for (int k = 0; k < NB; k++) begin
      c = sel ? mem_b[k] : mem_a[k];
      t = t + TW'(c);
      if (c > mc) begin
        mc = c;
        mb = DSIZE'(k);
      end
      lst = !sel && (k == NB - 1);
      if (!(sel && (c == 32'd0))) begin
        if (sel) exp_b_q.push_back({lst, DSIZE'(k), c});
        else     exp_a_q.push_back({lst, DSIZE'(k), c});
      end
    end
    exp_total   = t;
    exp_max_cnt = mc;
    exp_max_bin = mb;
  endtask

  // Monitor A: entry compare, stall stability, done behaviour.
  int pops_a = 0, done_cnt_a = 0, neg_cnt_a = 0, last_pop_a = 0;
  bit stall_prev_a = 0, ab_prev_a = 0, done_prev_a = 0;
  logic [EW-1:0] held_a;
  logic [EW-1:0] ea;
  always @(negedge clock) begin
    if (!rst_n) begin
      stall_prev_a = 0; ab_prev_a = 0; done_prev_a = 0;
    end else begin
      neg_cnt_a++;
      check("get_summary_a", get_summary_a, busy_a && !done_a);
      if (stall_prev_a && !ab_prev_a)
        check("stall_hold_a", {out_vld_a, out_last_a, out_bin_a, out_cnt_a}, {1'b1, held_a});
      if (out_vld_a && out_rdy_a) begin
        check("entry_expected_a", exp_a_q.size() != 0, 1);
        if (exp_a_q.size() != 0) begin
          ea = exp_a_q.pop_front();
          check("entry_a", {out_last_a, out_bin_a, out_cnt_a}, ea);
        end
        pops_a++;
        last_pop_a = neg_cnt_a;
      end
      stall_prev_a = out_vld_a && !out_rdy_a;
      held_a       = {out_last_a, out_bin_a, out_cnt_a};
      ab_prev_a    = abort_a;
      if (done_a) begin
        done_cnt_a++;
        check("done_width_a", done_prev_a, 0);
        check("done_drained_a", exp_a_q.size(), 0);
        check("done_after_pop_a", neg_cnt_a - last_pop_a, 2);
      end
      done_prev_a = done_a;
    end
  end

  // Monitor B: entry compare, stall stability, done behaviour.
  int done_cnt_b = 0;
  bit stall_prev_b = 0, done_prev_b = 0;
  logic [EW-1:0] held_b;
  logic [EW-1:0] eb;
  always @(negedge clock) begin
    if (!rst_n) begin
      stall_prev_b = 0; done_prev_b = 0;
    end else begin
      if (stall_prev_b)
        check("stall_hold_b", {out_vld_b, out_last_b, out_bin_b, out_cnt_b}, {1'b1, held_b});
      if (out_vld_b && out_rdy_b) begin
        check("entry_expected_b", exp_b_q.size() != 0, 1);
        if (exp_b_q.size() != 0) begin
          eb = exp_b_q.pop_front();
          check("entry_b", {out_last_b, out_bin_b, out_cnt_b}, eb);
        end
      end
      stall_prev_b = out_vld_b && !out_rdy_b;
      held_b       = {out_last_b, out_bin_b, out_cnt_b};
      if (done_b) begin
        done_cnt_b++;
        check("done_width_b", done_prev_b, 0);
        check("done_drained_b", exp_b_q.size(), 0);
      end
      done_prev_b = done_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero_a(input string tag);
    check({tag, "_ctrl"}, {out_vld_a, out_last_a, out_bin_a, busy_a, done_a,
                           get_summary_a, index_a, max_bin_a, state_a}, '0);
    check({tag, "_cnt"},  {out_cnt_a, max_cnt_a}, '0);
    check({tag, "_total"}, total_a, '0);
  endtask

  task automatic start(input bit sel, input bit measure_lat);
    int lat;
    load_expect(sel);
    @(posedge clock); #1;
    if (sel) dump_req_b = 1'b1; else dump_req_a = 1'b1;
    @(posedge clock); #1;
    dump_req_a = 1'b0; dump_req_b = 1'b0;
    @(negedge clock);
    check(sel ? "start_busy_b" : "start_busy_a", sel ? busy_b : busy_a, 1);
    check(sel ? "start_clear_b" : "start_clear_a",
          sel ? {total_b, max_cnt_b, max_bin_b, index_b} : {total_a, max_cnt_a, max_bin_a, index_a}, '0);
    if (measure_lat) begin
      lat = 0;
      while (!out_vld_a && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      check("first_vld_latency", lat, RD_LAT + 1);
    end
  endtask

  task automatic wait_done(input bit sel, input int budget, input int mode);
    int cyc;
    bit got;
    logic r;
    cyc = 0; got = 0;
    while (!got && cyc < budget) begin
      @(posedge clock); #1;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (sel) out_rdy_b = r; else out_rdy_a = r;
      cyc++;
      @(negedge clock);
      got = sel ? done_b : done_a;
    end
    check(sel ? "done_seen_b" : "done_seen_a", got, 1);
    if (got) begin
      check(sel ? "total_b" : "total_a", sel ? total_b : total_a, exp_total);
      check(sel ? "max_b" : "max_a", sel ? {max_bin_b, max_cnt_b} : {max_bin_a, max_cnt_a},
            {exp_max_bin, exp_max_cnt});
    end
    @(negedge clock);
    check(sel ? "idle_after_done_b" : "idle_after_done_a",
          sel ? {busy_b, done_b} : {busy_a, done_a}, 2'b00);
    out_rdy_a = 1'b1; out_rdy_b = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc, guard;
    for (int k = 0; k < NB; k++) begin
      mem_a[k] = 32'(k);
      mem_b[k] = 32'd0;
    end
    mem_b[3] = 32'd7;
    mem_b[9] = 32'd7;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_a("reset_a");
    check("reset_b", {out_vld_b, busy_b, done_b, total_b, max_cnt_b}, '0);
    @(posedge clock); #1 rst_n = 1'b1;

    // Ramp data, full-rate sink.
    start(0, 1);
    wait_done(0, 400, 0);
    check("t1_total_const", total_a, 120);
    check("t1_max_const", {max_bin_a, max_cnt_a}, {4'd15, 32'd15});

    // Same data, sink ready one cycle in three.
    start(0, 0);
    wait_done(0, 400, 1);

    // Sparse data, zero bins suppressed, tie on peak.
    start(1, 0);
    wait_done(1, 400, 0);
    check("t3_total_const", total_b, 14);
    check("t3_max_bin_const", max_bin_b, 3);
    check("t3_done_count", done_cnt_b, 1);

    // Abort while the 5th entry is at the head, then restart.
    out_rdy_a = 1'b1;
    start(0, 0);
    guard = 0;
    while (pops_a % NB < 4 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    check("abort_reached", guard < 200, 1);
    out_rdy_a = 1'b0;
    abort_a   = 1'b1;
    dc = done_cnt_a;
    @(posedge clock); #1 abort_a = 1'b0;
    @(negedge clock);
    check("abort_busy", busy_a, 0);
    check("abort_vld", out_vld_a, 0);
    exp_a_q.delete();
    repeat (5) @(negedge clock);
    check("abort_no_done", done_cnt_a - dc, 0);
    out_rdy_a = 1'b1;
    start(0, 0);
    wait_done(0, 400, 0);

    // Reset mid-sweep, then a dump_req while busy must be ignored.
    start(0, 0);
    repeat (6) @(posedge clock);
    #1 rst_n = 1'b0;
    @(negedge clock);
    check_zero_a("mid_reset_a");
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    exp_a_q.delete();
    @(negedge clock);
    check_zero_a("post_reset_a");
    dc = done_cnt_a;
    start(0, 0);
    repeat (4) @(posedge clock);
    #1 dump_req_a = 1'b1;
    @(posedge clock); #1 dump_req_a = 1'b0;
    wait_done(0, 400, 0);
    check("busy_dump_single_done", done_cnt_a - dc, 1);

    // Saturated count propagates unchanged; total needs the wide accumulator.
    mem_a[2] = 32'hFFFF_FFFF;
    start(0, 0);
    wait_done(0, 400, 0);
    check("t6_total_const", total_a, 36'h1_0000_0075);
    check("t6_max_bin_const", max_bin_a, 2);

    // Random counts (ties likely) with a random sink.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NB; k++) mem_a[k] = $urandom_range(0, 20);
      start(0, 0);
      wait_done(0, 600, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
